// File: rtl/nib_list_serializer.sv
// nib_list_serializer: accepts one frame of up to four 4-bit elements plus a
// length in a single handshake, then streams the elements out one per beat
// (element 0 first) under valid/ready flow control, flagging the final beat.
//
// Optional feature macro: NIB_SER_STATS_EN -- when defined, frame_cnt is an
// 8-bit wrapping count of completed frames; otherwise frame_cnt is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   frame offered
//   in_ready   block can accept a frame (high in IDLE)
//   in_len     element count, legal 0..4 (5..7 clamped to 4 with len_err)
//   in_data    packed elements, element k in bits [4k+3:4k]
//   out_valid  beat valid
//   out_ready  consumer accepts beat
//   out_data   current element
//   out_last   current beat is the final element of the frame
//   len_err    one-cycle pulse after accepting a frame with in_len > 4
//   frame_cnt  completed-frame counter (0 unless NIB_SER_STATS_EN)
module nib_list_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_len,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_data,
  output logic        out_last,
  output logic        len_err,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned ElemW  = 4;
  localparam int unsigned Depth  = 4;
  localparam int unsigned DataW  = ElemW * Depth;
  localparam int unsigned LenW   = 3;
  localparam int unsigned IdxW   = 2;
  localparam int unsigned CntW   = 8;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  state_e            state_q, state_d;
  logic [DataW-1:0]  hold_q, hold_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              len_err_q, len_err_d;
  logic              is_last_c;
  logic              send_c;

  assign send_c    = (state_q == ST_SEND);
  assign is_last_c = (LenW'(idx_q) == (len_q - LenW'(1)));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      len_err_q <= len_err_d;
    end
  end

  // Next-state: accept in IDLE, step through elements in SEND
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    len_d     = len_q;
    idx_d     = idx_q;
    len_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          hold_d = in_data;
          idx_d  = '0;
          if (in_len == LenW'(0)) begin
            // Empty frame: consumed with no beats
            len_d = '0;
          end else if (in_len > LenW'(Depth)) begin
            len_d     = LenW'(Depth);
            len_err_d = 1'b1;
            state_d   = ST_SEND;
          end else begin
            len_d   = in_len;
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (is_last_c) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registers only; data/last forced to 0 outside SEND
  assign in_ready  = ~send_c;
  assign out_valid = send_c;
  assign out_data  = send_c ? hold_q[{idx_q, 2'b00} +: ElemW] : '0;
  assign out_last  = send_c & is_last_c;
  assign len_err   = len_err_q;

`ifdef NIB_SER_STATS_EN
  logic [CntW-1:0] frame_cnt_q, frame_cnt_d;

  // Count frames whose last beat has transferred; wraps naturally
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (send_c && out_ready && is_last_c) begin
      frame_cnt_d = frame_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = CntW'(0);
`endif

endmodule
